// File: rtl/trng_collector.sv
// trng_collector: conditioning and packing stage behind the ring-oscillator
// entropy macro. Synchronizes the raw bit, samples it at a fixed divider rate,
// runs a repetition-count health test, Von Neumann debiases, packs WIDTH-bit
// words and hands them out over valid/ready.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | rings held in reset, waiting for en_i
// ST_WARMUP  | rings running, first WARMUP samples discarded
// ST_COLLECT | samples feed health test, debiaser and packer
// ST_FAIL    | repetition test tripped, rings held in reset until clr_fail_i
module trng_collector #(
  parameter int WIDTH      = 32,
  parameter int SAMPLE_DIV = 8,
  parameter int WARMUP     = 64,
  parameter int REP_LIMIT  = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             raw_i,
  output logic             ring_rst_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             health_fail_o,
  input  logic             clr_fail_i
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WU_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [7:0]       REP_TRIP = 8'(REP_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_COLLECT,
    ST_FAIL
  } state_t;

  state_t state, state_nxt;
  logic   ring_rst_nxt;

  logic             raw_m, raw_s;
  logic [DIV_W-1:0] div_cnt;
  logic [WU_W-1:0]  wu_cnt;
  logic [7:0]       rep_cnt, rep_next;
  logic             prev_smp, first_smp;
  logic             pair_phase, pair_a;
  logic [WIDTH-1:0] shift;
  logic [CNT_W-1:0] bit_cnt;

  logic running, disable_req, strobe, collect_smp, fail_hit, emit, handoff;

  // Datapath qualifiers shared by the FSM and the sequential blocks
  assign running     = en_i && (state == ST_WARMUP || state == ST_COLLECT);
  assign disable_req = !en_i && (state == ST_WARMUP || state == ST_COLLECT);
  assign strobe      = running && (div_cnt == DIV_LAST);
  assign collect_smp = strobe && (state == ST_COLLECT);
  assign rep_next    = (first_smp || (raw_s != prev_smp)) ? 8'd1 :
                       ((rep_cnt == 8'hFF) ? 8'hFF : rep_cnt + 8'd1);
  assign fail_hit    = collect_smp && (rep_next >= REP_TRIP);
  // A failing sample never produces a debiased bit
  assign emit        = collect_smp && !fail_hit && pair_phase && (pair_a != raw_s);
  // Hand the full shifter to the output when it is empty or draining this cycle
  assign handoff     = (bit_cnt == CNT_FULL) && (!valid_o || ready_i);

  // Two-flop synchronizer for the free-running ring output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raw_m <= 1'b0;
      raw_s <= 1'b0;
    end else begin
      raw_m <= raw_i;
      raw_s <= raw_m;
    end
  end

  // State register; ring reset is registered alongside the state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      ring_rst_o <= 1'b1;
    end else begin
      state      <= state_nxt;
      ring_rst_o <= ring_rst_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    ring_rst_nxt = 1'b1;
    case (state)
      ST_IDLE: begin
        if (en_i) state_nxt = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (!en_i) state_nxt = ST_IDLE;
        else if (strobe && (wu_cnt == WU_LAST)) state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!en_i) state_nxt = ST_IDLE;
        else if (fail_hit) state_nxt = ST_FAIL;
      end
      ST_FAIL: begin
        if (clr_fail_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    ring_rst_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_FAIL);
  end

  // Sample divider: free-runs only while the rings are enabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt <= '0;
    end else if (!running || strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Warm-up strobe counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wu_cnt <= '0;
    end else if (state != ST_WARMUP || !en_i) begin
      wu_cnt <= '0;
    end else if (strobe) begin
      wu_cnt <= (wu_cnt == WU_LAST) ? '0 : wu_cnt + WU_W'(1);
    end
  end

  // Repetition-count health test; first_smp forces a fresh run on COLLECT entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt   <= '0;
      prev_smp  <= 1'b0;
      first_smp <= 1'b1;
    end else if (state == ST_COLLECT && en_i) begin
      if (collect_smp) begin
        rep_cnt   <= rep_next;
        prev_smp  <= raw_s;
        first_smp <= 1'b0;
      end
    end else begin
      rep_cnt   <= '0;
      prev_smp  <= 1'b0;
      first_smp <= 1'b1;
    end
  end

  // Sticky failure flag; a clear coinciding with a trip cannot happen outside FAIL
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      health_fail_o <= 1'b0;
    end else if (fail_hit) begin
      health_fail_o <= 1'b1;
    end else if (state == ST_FAIL && clr_fail_i) begin
      health_fail_o <= 1'b0;
    end
  end

  // Debiaser pair tracking, packer shifter and output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pair_phase <= 1'b0;
      pair_a     <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
    end else if (disable_req) begin
      // partial word is abandoned, a completed output word stays available
      pair_phase <= 1'b0;
      pair_a     <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      if (valid_o && ready_i) valid_o <= 1'b0;
    end else if (fail_hit) begin
      pair_phase <= 1'b0;
      pair_a     <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
    end else begin
      if (state != ST_COLLECT) begin
        pair_phase <= 1'b0;
      end else if (collect_smp) begin
        pair_phase <= ~pair_phase;
        if (!pair_phase) pair_a <= raw_s;
      end

      if (handoff) begin
        data_o  <= shift;
        valid_o <= 1'b1;
        if (emit) begin
          shift   <= {shift[WIDTH-2:0], pair_a};
          bit_cnt <= CNT_W'(1);
        end else begin
          bit_cnt <= '0;
        end
      end else begin
        if (valid_o && ready_i) valid_o <= 1'b0;
        // with a full shifter and a blocked output, new bits are dropped
        if (emit && bit_cnt != CNT_FULL) begin
          shift   <= {shift[WIDTH-2:0], pair_a};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Testbench for trng_collector: small configuration (WIDTH=8, SAMPLE_DIV=1,
// WARMUP=4) for functional scenarios, default configuration for sample rate.
module tb_trng_collector;

  localparam int W  = 8;
  localparam int SD = 1;
  localparam int WU = 4;
  localparam int RL = 32;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst_ni;
  logic         en_a, raw_a, ready_a, clr_a;
  logic         ring_rst_a, valid_a, health_a;
  logic [W-1:0] data_a;
  logic         en_b, raw_b, ready_b, clr_b;
  logic         ring_rst_b, valid_b, health_b;
  logic [31:0]  data_b;

  trng_collector #(.WIDTH(W), .SAMPLE_DIV(SD), .WARMUP(WU), .REP_LIMIT(RL)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_a), .raw_i(raw_a),
    .ring_rst_o(ring_rst_a), .data_o(data_a), .valid_o(valid_a),
    .ready_i(ready_a), .health_fail_o(health_a), .clr_fail_i(clr_a)
  );

  trng_collector dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_b), .raw_i(raw_b),
    .ring_rst_o(ring_rst_b), .data_o(data_b), .valid_o(valid_b),
    .ready_i(ready_b), .health_fail_o(health_b), .clr_fail_i(clr_b)
  );

  int checks = 0;
  int errors = 0;

  bit           stim[$];
  bit           col[$];
  logic [W-1:0] exp_words[$];
  logic [W-1:0] got[$];
  int           exp_fail;
  int           exp_nbits;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // random bits, with long runs broken so the health test does not trip
  task automatic add_random(input int n);
    bit b;
    int r;
    r = 0;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      if (stim.size() > 0 && r >= 8 && b == stim[$]) b = ~b;
      if (stim.size() > 0 && b == stim[$]) r++; else r = 1;
      stim.push_back(b);
    end
  endtask

  task automatic add_unequal(input int npairs);
    bit a;
    for (int i = 0; i < npairs; i++) begin
      a = 1'($urandom_range(0, 1));
      stim.push_back(a);
      stim.push_back(~a);
    end
  endtask

  task automatic add_tail;
    stim.push_back(1'b1);
    stim.push_back(1'b1);
    add_random(2);
  endtask

  // Reference: raw bit k driven after en_i is the COLLECT sample k-(WU-1);
  // the last two driven bits are never sampled before the bench disables.
  task automatic run_model;
    int run;
    int nb;
    logic [W-1:0] acc;
    col.delete();
    for (int i = WU - 1; i <= stim.size() - 3; i++) col.push_back(stim[i]);
    exp_words.delete();
    exp_fail = -1;
    run = 0;
    nb = 0;
    acc = '0;
    for (int i = 0; i < col.size(); i++) begin
      if (i == 0 || col[i] != col[i-1]) run = 1; else run++;
      if (run >= RL) begin
        exp_fail = i;
        break;
      end
      if (i % 2 == 1 && col[i-1] != col[i]) begin
        acc = {acc[W-2:0], col[i-1]};
        nb++;
        if (nb % W == 0) exp_words.push_back(acc);
      end
    end
    exp_nbits = nb;
  endtask

  task automatic run_stim(input bit rdy);
    for (int k = 0; k < stim.size(); k++) begin
      en_a = 1'b1; raw_a = stim[k]; ready_a = rdy; clr_a = 1'b0;
      if (valid_a && ready_a) got.push_back(data_a);
      tick();
      if (k == 0) chk("ring_rst_low_after_en", ring_rst_a, 1'b0);
    end
  endtask

  task automatic drain;
    en_a = 1'b0; ready_a = 1'b1; clr_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (valid_a && ready_a) got.push_back(data_a);
      tick();
    end
  endtask

  task automatic compare_words(input string tag);
    int n;
    chk({tag, "_count"}, got.size(), exp_words.size());
    n = (got.size() < exp_words.size()) ? got.size() : exp_words.size();
    for (int i = 0; i < n; i++) chk({tag, "_word"}, got[i], exp_words[i]);
  endtask

  int kf;
  int times[$];
  bit pat[8];

  initial begin
    rst_ni = 1'b0;
    en_a = 0; raw_a = 0; ready_a = 0; clr_a = 0;
    en_b = 0; raw_b = 0; ready_b = 0; clr_b = 0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      en_a = 1'($urandom); raw_a = 1'($urandom); ready_a = 1'($urandom); clr_a = 1'($urandom);
      en_b = 1'($urandom); raw_b = 1'($urandom);
      tick();
    end
    chk("rst_ring_rst", ring_rst_a, 1'b1);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_data", data_a, '0);
    chk("rst_health", health_a, 1'b0);
    chk("rst_ring_rst_b", ring_rst_b, 1'b1);
    en_a = 0; clr_a = 0; ready_a = 0; en_b = 0;
    rst_ni = 1'b1;
    repeat (3) tick();
    chk("idle_ring_rst", ring_rst_a, 1'b1);
    chk("idle_valid", valid_a, 1'b0);

    // directed debias pattern 10,01,11,00 -> 8'hAA
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    stim.delete();
    add_random(WU - 1);
    for (int g = 0; g < 4; g++) for (int i = 0; i < 8; i++) stim.push_back(pat[i]);
    add_tail();
    run_model();
    got.delete();
    run_stim(1'b1);
    drain();
    compare_words("debias_aa");
    if (got.size() > 0) chk("debias_aa_value", got[0], 8'hAA);
    else chk("debias_aa_present", got.size(), 1);

    // randomized streams with ready held high
    for (int r = 0; r < 3; r++) begin
      stim.delete();
      add_random(WU - 1 + 120);
      add_tail();
      run_model();
      got.delete();
      run_stim(1'b1);
      drain();
      compare_words("random");
      chk("random_health", health_a, 1'b0);
    end

    // backpressure: two full words, later bits dropped
    stim.delete();
    add_random(WU - 1);
    add_unequal(20);
    add_tail();
    run_model();
    for (int k = 0; k < stim.size(); k++) begin
      en_a = 1'b1; raw_a = stim[k]; ready_a = 1'b0; clr_a = 1'b0;
      tick();
      if (valid_a) chk("bp_first_stable", data_a, exp_words[0]);
    end
    chk("bp_first_valid", valid_a, 1'b1);
    ready_a = 1'b1; raw_a = 1'b0;
    tick();
    ready_a = 1'b0;
    chk("bp_second_valid", valid_a, 1'b1);
    chk("bp_second_word", data_a, exp_words[1]);
    tick();
    chk("bp_second_stable", data_a, exp_words[1]);

    // asynchronous reset mid-operation
    #3 rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", valid_a, 1'b0);
    chk("async_rst_data", data_a, '0);
    chk("async_rst_ring", ring_rst_a, 1'b1);
    en_a = 1'b0; ready_a = 1'b0;
    tick();
    rst_ni = 1'b1;
    repeat (2) tick();

    // health failure with clear pulse colliding with the trip
    stim.delete();
    add_random(WU - 1);
    add_unequal(7);
    stim.push_back(1'b1);
    stim.push_back(1'b0);
    for (int i = 0; i < 40; i++) stim.push_back(1'b1);
    run_model();
    chk("hf_model_trips", (exp_fail >= 0), 1'b1);
    kf = WU - 1 + exp_fail + 2;
    for (int k = 0; k < stim.size(); k++) begin
      en_a = 1'b1; raw_a = stim[k]; ready_a = 1'b0; clr_a = (k == kf);
      tick();
      if (k == kf - 1) begin
        chk("hf_before_health", health_a, 1'b0);
        chk("hf_before_valid", valid_a, 1'b1);
        chk("hf_before_word", data_a, exp_words[0]);
      end
      if (k == kf) begin
        chk("hf_health", health_a, 1'b1);
        chk("hf_ring_rst", ring_rst_a, 1'b1);
        chk("hf_valid", valid_a, 1'b0);
        chk("hf_data", data_a, '0);
      end
    end
    chk("hf_sticky", health_a, 1'b1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("hf_cleared", health_a, 1'b0);
    chk("hf_idle_ring", ring_rst_a, 1'b1);
    tick();
    chk("hf_rewarm_ring", ring_rst_a, 1'b0);
    en_a = 1'b0;
    repeat (2) tick();

    // disable with 5 bits packed, then a fresh word from new bits only
    stim.delete();
    add_random(WU - 1);
    add_unequal(5);
    add_tail();
    got.delete();
    run_stim(1'b1);
    en_a = 1'b0;
    tick();
    chk("dis_ring_rst", ring_rst_a, 1'b1);
    chk("dis_no_word", valid_a, 1'b0);
    tick();
    stim.delete();
    add_random(WU - 1);
    add_unequal(8);
    add_tail();
    run_model();
    got.delete();
    run_stim(1'b1);
    drain();
    compare_words("reenable");

    // sample rate on default configuration
    times.delete();
    for (int c = 0; c < 2600 && times.size() < 3; c++) begin
      en_b = 1'b1; ready_b = 1'b1; clr_b = 1'b0;
      raw_b = 1'((c / 8) % 2);
      tick();
      if (valid_b) begin
        times.push_back(c);
        chk("rate_word_uniform", ((data_b === 32'h0) || (data_b === 32'hFFFF_FFFF)), 1'b1);
      end
    end
    chk("rate_words_seen", times.size(), 3);
    if (times.size() == 3) begin
      chk("rate_period_1", times[1] - times[0], 512);
      chk("rate_period_2", times[2] - times[1], 512);
    end
    chk("rate_health", health_b, 1'b0);
    en_b = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
